// File: rtl/cache_fill_arbiter.sv
// Shares one multi-cycle memory between I/D cache block fills and write-through stores.
// Optional CACHE_ARB_ROUND_ROBIN_EN: alternate I/D miss priority on ties.
module cache_fill_arbiter #(
  parameter int MEM_LATENCY     = 4,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int IW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_miss,
  input  logic [15:0]   i_miss_addr,
  input  logic          d_miss,
  input  logic [15:0]   d_miss_addr,
  input  logic          st_req,
  input  logic [15:0]   st_addr,
  input  logic [15:0]   st_data,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [15:0]   mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_data_valid,
  input  logic [15:0]   mem_rdata,
  output logic          fill_we_i,
  output logic          fill_we_d,
  output logic [IW-1:0] fill_idx,
  output logic [15:0]   fill_data,
  output logic          i_fill_done,
  output logic          d_fill_done,
  output logic          i_stall,
  output logic          d_stall,
  output logic          st_ack
);

  if (MEM_LATENCY < 1) begin : g_bad_lat
    $error("MEM_LATENCY must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  localparam logic [15:0]   BMASK = 16'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [IW-1:0] LAST  = IW'(WORDS_PER_BLOCK - 1);

  state_t        state_q, state_d;
  logic          own_d_q, own_d_d;
  logic [15:0]   base_q, base_d;
  logic [IW-1:0] iss_q, iss_d;
  logic [IW-1:0] ret_q, ret_d;

  logic idle, busy, d_pri, st_go, grant_d, grant_i;

  assign idle = (state_q == IDLE);
  assign busy = (state_q == FILL) | (state_q == DRAIN);

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // own_d_q holds the last-served owner; it loses a tie
  assign d_pri = d_miss & ~(i_miss & own_d_q);
`else
  assign d_pri = d_miss;
`endif

  assign st_go   = idle & ~d_pri & st_req;
  assign grant_d = idle & d_pri;
  assign grant_i = idle & ~d_pri & ~st_req & i_miss;

  always_comb begin
    state_d = state_q;
    own_d_d = own_d_q;
    base_d  = base_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE: begin
        iss_d = '0;
        ret_d = '0;
        if (grant_d | grant_i) begin
          own_d_d = grant_d;
          base_d  = (grant_d ? d_miss_addr : i_miss_addr) & ~BMASK;
          state_d = FILL;
        end
      end
      FILL: begin
        iss_d = iss_q + 1'b1;
        if (iss_q == LAST) state_d = DRAIN;
        if (mem_data_valid) ret_d = ret_q + 1'b1;
      end
      DRAIN: begin
        if (mem_data_valid) begin
          ret_d = ret_q + 1'b1;
          if (ret_q == LAST) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_d_q <= 1'b0;
      base_q  <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      base_q  <= base_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    mem_en    = st_go | (state_q == FILL);
    mem_wr    = st_go;
    mem_wdata = st_go ? st_data : 16'h0;
    mem_addr  = 16'h0;
    if (st_go)
      mem_addr = st_addr;
    else if (state_q == FILL)
      mem_addr = base_q | 16'({iss_q, 1'b0});
  end

  assign st_ack      = st_go;
  assign fill_we_i   = mem_data_valid & busy & ~own_d_q;
  assign fill_we_d   = mem_data_valid & busy & own_d_q;
  assign fill_idx    = ret_q;
  assign fill_data   = mem_rdata;
  assign i_fill_done = (state_q == DONE) & ~own_d_q;
  assign d_fill_done = (state_q == DONE) & own_d_q;
  assign i_stall     = i_miss | (~own_d_q & ~idle);
  assign d_stall     = d_miss | (st_req & ~st_go) | (own_d_q & ~idle);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: default instance plus a
// WORDS_PER_BLOCK=4 / MEM_LATENCY=1 instance, each with a latency-pipe memory.
module tb_cache_fill_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // default instance
  logic        i_miss0, d_miss0, st_req0;
  logic [15:0] i_addr0, d_addr0, st_addr0, st_data0;
  logic        mem_en0, mem_wr0, mem_dv0;
  logic [15:0] mem_addr0, mem_wdata0, mem_rdata0, fill_data0;
  logic        fwe_i0, fwe_d0, idone0, ddone0, istall0, dstall0, ack0;
  logic [2:0]  fidx0;

  // small instance
  logic        i_miss1, d_miss1, st_req1;
  logic [15:0] i_addr1, d_addr1, st_addr1, st_data1;
  logic        mem_en1, mem_wr1, mem_dv1;
  logic [15:0] mem_addr1, mem_wdata1, mem_rdata1, fill_data1;
  logic        fwe_i1, fwe_d1, idone1, ddone1, istall1, dstall1, ack1;
  logic [1:0]  fidx1;

  cache_fill_arbiter #(.MEM_LATENCY(4), .WORDS_PER_BLOCK(8)) dut0 (
    .clk(clk), .rst(rst),
    .i_miss(i_miss0), .i_miss_addr(i_addr0),
    .d_miss(d_miss0), .d_miss_addr(d_addr0),
    .st_req(st_req0), .st_addr(st_addr0), .st_data(st_data0),
    .mem_en(mem_en0), .mem_wr(mem_wr0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_data_valid(mem_dv0),
    .mem_rdata(mem_rdata0),
    .fill_we_i(fwe_i0), .fill_we_d(fwe_d0), .fill_idx(fidx0),
    .fill_data(fill_data0),
    .i_fill_done(idone0), .d_fill_done(ddone0),
    .i_stall(istall0), .d_stall(dstall0), .st_ack(ack0)
  );

  cache_fill_arbiter #(.MEM_LATENCY(1), .WORDS_PER_BLOCK(4)) dut1 (
    .clk(clk), .rst(rst),
    .i_miss(i_miss1), .i_miss_addr(i_addr1),
    .d_miss(d_miss1), .d_miss_addr(d_addr1),
    .st_req(st_req1), .st_addr(st_addr1), .st_data(st_data1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_data_valid(mem_dv1),
    .mem_rdata(mem_rdata1),
    .fill_we_i(fwe_i1), .fill_we_d(fwe_d1), .fill_idx(fidx1),
    .fill_data(fill_data1),
    .i_fill_done(idone1), .d_fill_done(ddone1),
    .i_stall(istall1), .d_stall(dstall1), .st_ack(ack1)
  );

  // memory models: read data = address ^ A5A5, never reset
  logic        v0 [4];
  logic [15:0] a0 [4];
  logic        v1;
  logic [15:0] a1;

  initial begin
    for (int i = 0; i < 4; i++) begin
      v0[i] = 1'b0;
      a0[i] = 16'h0;
    end
    v1 = 1'b0;
    a1 = 16'h0;
  end

  always @(posedge clk) begin
    v0[0] <= mem_en0 & ~mem_wr0;
    a0[0] <= mem_addr0;
    for (int i = 1; i < 4; i++) begin
      v0[i] <= v0[i-1];
      a0[i] <= a0[i-1];
    end
    v1 <= mem_en1 & ~mem_wr1;
    a1 <= mem_addr1;
  end

  assign mem_dv0    = v0[3];
  assign mem_rdata0 = a0[3] ^ 16'hA5A5;
  assign mem_dv1    = v1;
  assign mem_rdata1 = a1 ^ 16'hA5A5;

  task automatic chk(input string tag, input int c,
                     input logic [15:0] obs, input logic [15:0] ex);
    nchk++;
    assert (obs === ex) else begin
      nerr++;
      $error("FAIL %s @c%0d: observed %h expected %h", tag, c, obs, ex);
    end
  endtask

  task automatic edge_in();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {i_miss0, d_miss0, st_req0} = '0;
    {i_addr0, d_addr0, st_addr0, st_data0} = '0;
    {i_miss1, d_miss1, st_req1} = '0;
    {i_addr1, d_addr1, st_addr1, st_data1} = '0;
    edge_in();
    edge_in();
    chk("rst_mem_en", 0, 16'(mem_en0), 16'h0);
    chk("rst_stall", 0, 16'({istall0, dstall0}), 16'h0);
    chk("rst_fill", 0, 16'({fwe_i0, fwe_d0, idone0, ddone0}), 16'h0);
    chk("rst_ack", 0, 16'(ack0), 16'h0);
    chk("rst_mem_en1", 0, 16'(mem_en1), 16'h0);
    rst = 1'b0;
    edge_in();

    // I miss fill of block 0x0130
    i_miss0 = 1'b1;
    i_addr0 = 16'h0136;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      chk("t1_en", c, 16'(mem_en0), 16'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8)
        chk("t1_addr", c, mem_addr0, 16'(16'h0130 + 2 * (c - 1)));
      chk("t1_we_i", c, 16'(fwe_i0), 16'(c >= 5 && c <= 12));
      chk("t1_we_d", c, 16'(fwe_d0), 16'h0);
      if (c >= 5 && c <= 12) begin
        chk("t1_idx", c, 16'(fidx0), 16'(c - 5));
        chk("t1_data", c, fill_data0,
            16'(16'h0130 + 2 * (c - 5)) ^ 16'hA5A5);
      end
      chk("t1_done", c, 16'(idone0), 16'(c == 13));
      chk("t1_istall", c, 16'(istall0), 16'h1);
      edge_in();
      if (c == 13) i_miss0 = 1'b0;
    end

    // simultaneous D and I misses: D block 0x2000 first, then I 0x0040
    d_miss0 = 1'b1;
    d_addr0 = 16'h2008;
    i_miss0 = 1'b1;
    i_addr0 = 16'h0040;
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      chk("t2_en", c, 16'(mem_en0),
          16'((c >= 1 && c <= 8) || (c >= 15 && c <= 22)));
      if (c >= 1 && c <= 8)
        chk("t2_daddr", c, mem_addr0, 16'(16'h2000 + 2 * (c - 1)));
      if (c >= 15 && c <= 22)
        chk("t2_iaddr", c, mem_addr0, 16'(16'h0040 + 2 * (c - 15)));
      chk("t2_we_d", c, 16'(fwe_d0), 16'(c >= 5 && c <= 12));
      chk("t2_we_i", c, 16'(fwe_i0), 16'(c >= 19 && c <= 26));
      chk("t2_ddone", c, 16'(ddone0), 16'(c == 13));
      chk("t2_idone", c, 16'(idone0), 16'(c == 27));
      edge_in();
      if (c == 13) d_miss0 = 1'b0;
      if (c == 27) i_miss0 = 1'b0;
    end

    // store in idle: zero latency
    st_req0  = 1'b1;
    st_addr0 = 16'h1000;
    st_data0 = 16'hBEEF;
    @(negedge clk);
    chk("t3_en", 0, 16'(mem_en0), 16'h1);
    chk("t3_wr", 0, 16'(mem_wr0), 16'h1);
    chk("t3_addr", 0, mem_addr0, 16'h1000);
    chk("t3_wdata", 0, mem_wdata0, 16'hBEEF);
    chk("t3_ack", 0, 16'(ack0), 16'h1);
    chk("t3_dstall", 0, 16'(dstall0), 16'h0);
    edge_in();
    st_req0 = 1'b0;
    @(negedge clk);
    chk("t3_en_after", 1, 16'(mem_en0), 16'h0);
    chk("t3_ack_after", 1, 16'(ack0), 16'h0);
    edge_in();

    // store raised during an I fill is held until IDLE
    i_miss0 = 1'b1;
    i_addr0 = 16'h0300;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 13) begin
        chk("t4_ack_hold", c, 16'(ack0), 16'h0);
        chk("t4_wr_hold", c, 16'(mem_wr0), 16'h0);
        chk("t4_dstall", c, 16'(dstall0), 16'h1);
      end
      if (c == 13) chk("t4_idone", c, 16'(idone0), 16'h1);
      if (c == 14) begin
        chk("t4_ack", c, 16'(ack0), 16'h1);
        chk("t4_wr", c, 16'(mem_wr0), 16'h1);
        chk("t4_addr", c, mem_addr0, 16'h1234);
        chk("t4_wdata", c, mem_wdata0, 16'h5555);
      end
      if (c == 15) chk("t4_ack_end", c, 16'(ack0), 16'h0);
      edge_in();
      if (c == 1) begin
        st_req0  = 1'b1;
        st_addr0 = 16'h1234;
        st_data0 = 16'h5555;
      end
      if (c == 13) i_miss0 = 1'b0;
      if (c == 14) st_req0 = 1'b0;
    end

    // reset at issue_cnt=3 aborts the fill
    i_miss0 = 1'b1;
    i_addr0 = 16'h0500;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("t5_en", c, 16'(mem_en0), 16'(c >= 1));
      edge_in();
    end
    rst = 1'b1;
    i_miss0 = 1'b0;
    #1;
    chk("t5_rst_en", 4, 16'(mem_en0), 16'h0);
    chk("t5_rst_addr", 4, mem_addr0, 16'h0);
    chk("t5_rst_fill", 4, 16'({fwe_i0, idone0, istall0}), 16'h0);
    edge_in();
    rst = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk);
      if (c == 5) chk("t5_stale_seen", c, 16'(mem_dv0), 16'h1);
      chk("t5_stale_we", c, 16'({fwe_i0, fwe_d0}), 16'h0);
      edge_in();
    end
    d_miss0 = 1'b1;
    d_addr0 = 16'h0600;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) chk("t5_addr0", c, mem_addr0, 16'h0600);
      chk("t5_we_d", c, 16'(fwe_d0), 16'(c >= 5 && c <= 12));
      if (c >= 5 && c <= 12)
        chk("t5_idx", c, 16'(fidx0), 16'(c - 5));
      chk("t5_ddone", c, 16'(ddone0), 16'(c == 13));
      edge_in();
      if (c == 13) d_miss0 = 1'b0;
    end

    // small block, latency 1, top of address space
    d_miss1 = 1'b1;
    d_addr1 = 16'hFFFE;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      chk("t6_en", c, 16'(mem_en1), 16'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4)
        chk("t6_addr", c, mem_addr1, 16'(16'hFFF8 + 2 * (c - 1)));
      chk("t6_we_d", c, 16'(fwe_d1), 16'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        chk("t6_idx", c, 16'(fidx1), 16'(c - 2));
        chk("t6_data", c, fill_data1,
            16'(16'hFFF8 + 2 * (c - 2)) ^ 16'hA5A5);
      end
      chk("t6_ddone", c, 16'(ddone1), 16'(c == 6));
      edge_in();
      if (c == 6) d_miss1 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
